// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side controller.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;
  localparam int BUF_DEPTH     = 2;
  localparam int BUF_CNT_W     = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_chk.sv
// Property checker for fifo_reader: buffer overflow and output hold under backpressure.
module fifo_reader_chk
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_,
  input logic                 flush,
  input logic                 push,
  input logic [BUF_CNT_W-1:0] buf_cnt,
  input logic                 out_valid,
  input logic                 out_ready,
  input logic [WIDTH-1:0]     out_data
);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_) !(push && (buf_cnt == 2'd2))
  );

  a_hold_under_stall: assert property (
    @(posedge clk) disable iff (!rst_)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data))
  );

endmodule

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer; entry 0 is always the head presented downstream.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     head,
  output logic [BUF_CNT_W-1:0] cnt
);

  logic [WIDTH-1:0]     ent0_r;
  logic [WIDTH-1:0]     ent1_r;
  logic [BUF_CNT_W-1:0] cnt_r;

  // Entry storage and occupancy; a simultaneous push/pop keeps the count.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ent0_r <= '0;
      ent1_r <= '0;
      cnt_r  <= 2'd0;
    end else if (clear) begin
      ent0_r <= '0;
      ent1_r <= '0;
      cnt_r  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            ent0_r <= din;
          end else begin
            ent1_r <= din;
          end
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          ent0_r <= ent1_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd2) begin
            ent0_r <= ent1_r;
            ent1_r <= din;
          end else begin
            ent0_r <= din;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign head = ent0_r;
  assign cnt  = cnt_r;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the synchronous FIFO: issues reads, hides read latency, frames output.
// Optional build macro FIFO_READER_STATS_EN adds the 32-bit word_count output.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic             fifo_write,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]      word_count
`endif
);

  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  rd_state_e            state_r;
  rd_state_e            state_nxt_s;
  logic                 inflight_r;
  logic [BEAT_W-1:0]    beat_r;
  logic [BUF_CNT_W-1:0] buf_cnt_s;
  logic [WIDTH-1:0]     head_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 clear_s;
  logic [2:0]           occ_s;

  // Next-state selection; flush outranks enable.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nxt_s = FLUSH;
        end else if (enable) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (flush) begin
          state_nxt_s = FLUSH;
        end else if (!enable) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      FLUSH: begin
        if (!inflight_r && !flush) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Clearing whenever the next state is FLUSH also drops any word landing from an in-flight read.
  assign clear_s = (state_nxt_s == FLUSH);
  assign push_s  = inflight_r && !clear_s;
  assign pop_s   = out_valid && out_ready;
  assign occ_s   = {1'b0, buf_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};

  // Never read during a full-pointer read/write collision: the FIFO would silently drop it.
  assign fifo_read = (state_r == ACTIVE) && !fifo_empty && !(fifo_full && fifo_write)
                     && (occ_s < 3'd2);

  // FSM state and read-latency tracking.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r    <= IDLE;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= fifo_read;
    end
  end

  // Frame position, advanced by each delivered word.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      beat_r <= '0;
    end else if (clear_s) begin
      beat_r <= '0;
    end else if (pop_s) begin
      beat_r <= (beat_r == LAST_BEAT) ? '0 : (beat_r + BEAT_ONE);
    end else begin
      beat_r <= beat_r;
    end
  end

  fifo_reader_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_  (rst_),
    .clear (clear_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (fifo_data_out),
    .head  (head_s),
    .cnt   (buf_cnt_s)
  );

  assign out_valid = (buf_cnt_s != 2'd0);
  assign out_data  = head_s;
  assign out_last  = out_valid && (beat_r == LAST_BEAT);
  assign busy      = out_valid || inflight_r || (state_r == FLUSH);

`ifdef FIFO_READER_STATS_EN
  logic [31:0] word_count_r;

  // Delivered-word counter, saturating, cleared by flush.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      word_count_r <= 32'd0;
    end else if (clear_s) begin
      word_count_r <= 32'd0;
    end else if (pop_s && (word_count_r != 32'hFFFF_FFFF)) begin
      word_count_r <= word_count_r + 32'd1;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign word_count = word_count_r;
`endif

  fifo_reader_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst_      (rst_),
    .flush     (flush),
    .push      (push_s),
    .buf_cnt   (buf_cnt_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios then random traffic against a queue model.
module tb_fifo_reader;

  localparam int W  = 16;
  localparam int FL = 4;
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_FLUSH = 2;

  logic         clk = 1'b0;
  logic         rst_;
  logic         enable;
  logic         flush;
  logic         fifo_empty;
  logic         fifo_full;
  logic         fifo_write;
  logic         fifo_read;
  logic [W-1:0] fifo_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]  word_count;
`endif

  fifo_reader #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk           (clk),
    .rst_          (rst_),
    .enable        (enable),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_write    (fifo_write),
    .fifo_read     (fifo_read),
    .fifo_data_out (fifo_data_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .word_count    (word_count)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           mode_m;
  bit           infl_m;
  logic [W-1:0] infl_word_m;
  logic [W-1:0] buf_q[$];
  logic [W-1:0] fifo_q[$];
  int           beat_m;
  logic [31:0]  wc_m;
  logic [W-1:0] wr_seq;
  int           delivered;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle of the reference model: compare DUT against model, then advance the model.
  task automatic step();
    bit exp_valid, exp_read, exp_busy, exp_last, pop;
    int nmode, occ;
    if (!rst_) begin
      mode_m = M_IDLE; buf_q.delete(); infl_m = 1'b0; beat_m = 0; wc_m = 32'd0;
      check("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_last",  {31'd0, out_last},  32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_out_data",  {16'd0, out_data},  32'd0);
`ifdef FIFO_READER_STATS_EN
      check("rst_word_count", word_count, 32'd0);
`endif
      return;
    end
    exp_valid = (buf_q.size() != 0);
    exp_last  = exp_valid && (beat_m == FL - 1);
    exp_busy  = exp_valid || infl_m || (mode_m == M_FLUSH);
    pop       = exp_valid && out_ready;
    occ       = buf_q.size() + (infl_m ? 1 : 0) - (pop ? 1 : 0);
    exp_read  = (mode_m == M_ACTIVE) && !fifo_empty && !(fifo_full && fifo_write) && (occ < 2);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    check("fifo_read", {31'd0, fifo_read}, {31'd0, exp_read});
    check("out_last",  {31'd0, out_last},  {31'd0, exp_last});
    check("busy",      {31'd0, busy},      {31'd0, exp_busy});
    if (exp_valid) check("out_data", {16'd0, out_data}, {16'd0, buf_q[0]});
`ifdef FIFO_READER_STATS_EN
    check("word_count", word_count, wc_m);
`endif
    if (mode_m == M_FLUSH) nmode = flush ? M_FLUSH : (infl_m ? M_FLUSH : M_IDLE);
    else if (flush) nmode = M_FLUSH;
    else if (mode_m == M_IDLE) nmode = enable ? M_ACTIVE : M_IDLE;
    else nmode = enable ? M_ACTIVE : M_IDLE;
    if (pop) begin
      void'(buf_q.pop_front());
      beat_m = (beat_m + 1) % FL;
      if (wc_m != 32'hFFFF_FFFF) wc_m = wc_m + 32'd1;
      delivered++;
    end
    if (nmode == M_FLUSH) begin
      buf_q.delete(); beat_m = 0; wc_m = 32'd0;
    end else if (infl_m) begin
      buf_q.push_back(infl_word_m);
    end
    infl_m = exp_read;
    if (exp_read) infl_word_m = fifo_q.pop_front();
    if (fifo_write && !fifo_full) begin
      fifo_q.push_back(wr_seq);
      wr_seq = wr_seq + 16'd1;
    end
    mode_m = nmode;
  endtask

  task automatic cyc(input bit r, input bit e, input bit f, input bit rdy, input bit full, input bit wr);
    @(negedge clk);
    rst_ = r; enable = e; flush = f; out_ready = rdy; fifo_full = full; fifo_write = wr;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data_out = infl_word_m;
    #1;
    step();
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(wr_seq);
      wr_seq = wr_seq + 16'd1;
    end
  endtask

  initial begin
    rst_ = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b1;
    fifo_full = 1'b0; fifo_write = 1'b0; fifo_empty = 1'b0; fifo_data_out = '0;
    mode_m = M_IDLE; infl_m = 1'b0; infl_word_m = '0; beat_m = 0; wc_m = 32'd0;
    wr_seq = 16'd1; delivered = 0;
    preload(16);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // streaming 0x0001..0x0010
    repeat (24) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_count", delivered, 32'd16);
    // backpressure, collision, flush
    preload(12);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // mid-frame reset
    preload(8);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 400) != 0, ($urandom % 8) != 0, ($urandom % 50) == 0,
          ($urandom % 3) != 0, ($urandom % 6) == 0, ($urandom % 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
